// File: rtl/y86_mem_pkg.sv
// Shared definitions for the Y86 data-memory path: status codes, memory depth,
// arbiter state encoding and the memory-touching instruction codes.
package y86_mem_pkg;

    localparam logic [2:0] STAT_AOK = 3'b001;
    localparam logic [2:0] STAT_ADR = 3'b011;

    localparam int DMEM_DEPTH = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Memory-stage instructions that store to the data memory drive m_we.
    function automatic logic icode_is_write(input logic [3:0] icode);
        return (icode == I_RMMOVQ) || (icode == I_CALL) || (icode == I_PUSHQ);
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts arbitrations lost by the fetch requester and forces a fetch win once
// the count reaches STARVE_MAX; the count clears whenever fetch wins.
module arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_arb,
    input  logic i_f_req,
    input  logic i_f_win,
    output logic o_force_f
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_arb) begin
            if (i_f_win) begin
                r_cnt <= '0;
            end else if (i_f_req && (r_cnt != CW'(STARVE_MAX))) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_force_f = (r_cnt == CW'(STARVE_MAX));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one single-port data memory between the fetch (read-only) and memory
// stages, one access in flight, memory stage first with a fetch starvation guard.
module dmem_port_arbiter
    import y86_mem_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int DEPTH      = DMEM_DEPTH,
    parameter int AW         = $clog2(DEPTH),
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [63:0]       f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_err,
    input  logic              m_req,
    input  logic              m_we,
    input  logic [63:0]       m_addr,
    input  logic [DATA_W-1:0] m_wdata,
    output logic              m_gnt,
    output logic              m_rvalid,
    output logic [DATA_W-1:0] m_rdata,
    output logic              m_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int WAIT_CYC = (MEM_LAT > 1) ? MEM_LAT - 1 : 1;
    localparam int WW       = $clog2(WAIT_CYC + 1);

    arb_state_t        r_state;
    logic              r_owner_m;
    logic              r_we;
    logic              r_err;
    logic [WW-1:0]     r_wait_cnt;
    logic              r_f_gnt;
    logic              r_m_gnt;
    logic              r_f_rvalid;
    logic              r_m_rvalid;
    logic              r_f_err;
    logic              r_m_err;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [AW-1:0]     r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic              w_arb;
    logic              w_force_f;
    logic              w_f_win;
    logic              w_m_win;
    logic [63:0]       w_sel_addr;
    logic              w_sel_we;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_addr_err;
    logic              w_rd_pass;

    assign w_arb   = (r_state == IDLE);
    assign w_f_win = w_arb & f_req & (~m_req | w_force_f);
    assign w_m_win = w_arb & m_req & ~w_f_win;

    assign w_sel_addr  = w_m_win ? m_addr : f_addr;
    assign w_sel_we    = w_m_win & m_we;
    assign w_sel_wdata = w_sel_we ? m_wdata : '0;
    // Negative addresses are caught by the sign bit before the upper-bound test.
    assign w_addr_err  = w_sel_addr[63] | (w_sel_addr >= 64'(DEPTH));

    arb_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_arb    (w_arb),
        .i_f_req  (f_req),
        .i_f_win  (w_f_win),
        .o_force_f(w_force_f)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_owner_m   <= 1'b0;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_wait_cnt  <= '0;
            r_f_gnt     <= 1'b0;
            r_m_gnt     <= 1'b0;
            r_f_rvalid  <= 1'b0;
            r_m_rvalid  <= 1'b0;
            r_f_err     <= 1'b0;
            r_m_err     <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_f_gnt     <= 1'b0;
            r_m_gnt     <= 1'b0;
            r_f_rvalid  <= 1'b0;
            r_m_rvalid  <= 1'b0;
            r_f_err     <= 1'b0;
            r_m_err     <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            case (r_state)
                IDLE: begin
                    if (w_f_win || w_m_win) begin
                        r_state   <= ISSUE;
                        r_owner_m <= w_m_win;
                        r_we      <= w_sel_we;
                        r_err     <= w_addr_err;
                        r_f_gnt   <= w_f_win;
                        r_m_gnt   <= w_m_win;
                        if (!w_addr_err) begin
                            r_mem_en    <= 1'b1;
                            r_mem_we    <= w_sel_we;
                            r_mem_addr  <= w_sel_addr[AW-1:0];
                            r_mem_wdata <= w_sel_wdata;
                        end
                    end
                end
                ISSUE: begin
                    if (r_we || r_err || (MEM_LAT == 1)) begin
                        r_state    <= RESP;
                        r_f_rvalid <= ~r_owner_m;
                        r_m_rvalid <= r_owner_m;
                        r_f_err    <= ~r_owner_m & r_err;
                        r_m_err    <= r_owner_m & r_err;
                    end else begin
                        r_state    <= WAIT;
                        r_wait_cnt <= WW'(WAIT_CYC - 1);
                    end
                end
                WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_state    <= RESP;
                        r_f_rvalid <= ~r_owner_m;
                        r_m_rvalid <= r_owner_m;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Read data arrives from the array in the RESP cycle itself, so it is steered, not registered.
    assign w_rd_pass = (r_state == RESP) & ~r_we & ~r_err;

    assign f_gnt     = r_f_gnt;
    assign m_gnt     = r_m_gnt;
    assign f_rvalid  = r_f_rvalid;
    assign m_rvalid  = r_m_rvalid;
    assign f_err     = r_f_err;
    assign m_err     = r_m_err;
    assign f_rdata   = (w_rd_pass & ~r_owner_m) ? mem_rdata : '0;
    assign m_rdata   = (w_rd_pass & r_owner_m) ? mem_rdata : '0;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != IDLE);

endmodule
